// File: rtl/ifetch_unit.sv
// Instruction fetch engine: walks the PC, reads imem over req/ack, hands words to decode over valid/ready.
// Optional FETCH_TIMEOUT_EN adds a sticky fetch_err and a bounded ack wait.
module ifetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned PC_STEP        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic [31:0] pc,
   output logic        busy
`ifdef FETCH_TIMEOUT_EN
   ,
   output logic        fetch_err
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic [31:0] addr_q, addr_d;
   logic        valid_q, valid_d;
   logic        discard_q, discard_d;
   logic        redir;
   logic [31:0] redir_tgt;

`ifdef FETCH_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wcnt_q, wcnt_d, wcnt_inc;
   logic          err_q, err_d;
   assign wcnt_inc  = wcnt_q + CW'(1);
   assign fetch_err = err_q;
`endif

   // start outside IDLE behaves as a redirect back to the boot address
   assign redir     = redirect_valid | start;
   assign redir_tgt = start ? RESET_PC : {redirect_pc[31:2], 2'b00};

   assign imem_req   = (state_q == S_REQ) || (state_q == S_WAIT);
   assign imem_addr  = imem_req ? pc_q : addr_q;
   assign inst_valid = valid_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign pc         = pc_q;
   assign busy       = (state_q != S_IDLE);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      valid_d   = valid_q;
      discard_d = discard_q;
      addr_d    = imem_req ? pc_q : addr_q;
`ifdef FETCH_TIMEOUT_EN
      wcnt_d = wcnt_q;
      err_d  = start ? 1'b0 : err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               pc_d    = RESET_PC;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            state_d = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
            wcnt_d = '0;
`endif
            if (redir) begin
               pc_d      = redir_tgt;
               discard_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (redir)
               pc_d = redir_tgt;
            if (imem_ack) begin
               // a redirect landing with the ack makes this data stale too
               if (discard_q || redir) begin
                  discard_d = 1'b0;
                  state_d   = S_REQ;
               end else begin
                  inst_d    = imem_rdata;
                  inst_pc_d = pc_q;
                  valid_d   = 1'b1;
                  state_d   = S_HOLD;
               end
            end else begin
               if (redir)
                  discard_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
               wcnt_d = wcnt_inc;
               if (wcnt_inc == CW'(TIMEOUT_CYCLES)) begin
                  err_d     = 1'b1;
                  discard_d = 1'b0;
                  state_d   = S_IDLE;
               end
`endif
            end
         end
         S_HOLD: begin
            if (redir) begin
               valid_d = 1'b0;
               pc_d    = redir_tgt;
               state_d = S_REQ;
            end else if (inst_ready) begin
               valid_d = 1'b0;
               pc_d    = pc_q + 32'(PC_STEP);
               state_d = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         inst_q    <= '0;
         inst_pc_q <= '0;
         addr_q    <= '0;
         valid_q   <= 1'b0;
         discard_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         wcnt_q <= '0;
         err_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         addr_q    <= addr_d;
         valid_q   <= valid_d;
         discard_q <= discard_d;
`ifdef FETCH_TIMEOUT_EN
         wcnt_q <= wcnt_d;
         err_q  <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: table of fetch scenarios plus hand sequences for squash, start, reset and timeout.
module tb_ifetch_unit;

   localparam logic [31:0] K = 32'hAAAA_0001;

   logic        clk = 1'b0;
   logic        rst_n, start, redirect_valid, imem_req, imem_ack, inst_valid, inst_ready, busy;
   logic [31:0] redirect_pc, imem_addr, imem_rdata, inst, inst_pc, pc;
`ifdef FETCH_TIMEOUT_EN
   logic        fetch_err;
`endif

   ifetch_unit dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
      .pc(pc), .busy(busy)
`ifdef FETCH_TIMEOUT_EN
      , .fetch_err(fetch_err)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] sb[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // memory model: latches the address while requested, acks mem_dly cycles later with addr^K
   int          mem_dly = 1;
   bit          mem_en  = 1'b1;
   bit          mem_busy = 1'b0;
   int          mem_cnt = 0;
   logic [31:0] mem_addr = '0;
   initial begin
      imem_ack   = 1'b0;
      imem_rdata = '0;
   end
   always @(negedge clk) begin
      if (imem_ack) begin
         imem_ack <= 1'b0;
         mem_busy <= 1'b0;
      end else if (mem_busy) begin
         mem_cnt <= mem_cnt - 1;
         if (mem_cnt - 1 <= 0) begin
            imem_ack   <= 1'b1;
            imem_rdata <= mem_addr ^ K;
         end
      end else if (mem_en && imem_req) begin
         mem_busy <= 1'b1;
         mem_cnt  <= mem_dly;
         mem_addr <= imem_addr;
      end
   end

   // scoreboard: every accepted instruction must match the next expected PC
   always @(negedge clk) begin
      if (rst_n && inst_valid && inst_ready && !redirect_valid && !start) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_accept", inst_pc, 32'hFFFF_FFFF);
         end else begin
            logic [31:0] e;
            e = sb.pop_front();
            chk("acc_inst_pc", inst_pc, e);
            chk("acc_inst", inst, e ^ K);
         end
      end
   end

   typedef struct {
      int          dly;
      bit          r_req;
      bit          r_wait;
      logic [31:0] tgt_a;
      logic [31:0] tgt_b;
      int          hold;
      logic [31:0] exp_ipc;
      int          exp_lat;
   } vec_t;

   logic [31:0] m_pc;

   // precondition: #1 after the edge that put the DUT into REQ
   task automatic run_entry(input vec_t e);
      int lat;
      mem_dly        = e.dly;
      redirect_valid = e.r_req;
      redirect_pc    = e.tgt_a;
      @(negedge clk);
      chk("req_addr", imem_addr, m_pc);
      chk("req_hi", {31'b0, imem_req}, 32'd1);
      @(posedge clk); #1;
      redirect_valid = e.r_wait;
      redirect_pc    = e.tgt_b;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      lat = 2;
      while (!inst_valid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("valid_seen", {31'b0, inst_valid}, 32'd1);
      if (e.exp_lat != 0) chk("latency", lat, e.exp_lat);
      sb.push_back(e.exp_ipc);
      repeat (e.hold) begin
         @(negedge clk);
         chk("hold_valid", {31'b0, inst_valid}, 32'd1);
         chk("hold_pc", inst_pc, e.exp_ipc);
         chk("hold_no_req", {31'b0, imem_req}, 32'd0);
         @(posedge clk); #1;
      end
      inst_ready = 1'b1;
      @(posedge clk); #1;
      inst_ready = 1'b0;
      m_pc = e.exp_ipc + 32'd4;
      chk("pc_after_accept", pc, m_pc);
      chk("valid_after_accept", {31'b0, inst_valid}, 32'd0);
   endtask

   task automatic wait_valid(input string nm);
      int n = 0;
      while (!inst_valid && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      chk(nm, {31'b0, inst_valid}, 32'd1);
   endtask

   vec_t tbl[7];
   vec_t one;

   initial begin
      tbl[0] = '{1, 0, 0, 32'h0,       32'h0,          0, 32'h0000_0000, 2};
      tbl[1] = '{1, 0, 0, 32'h0,       32'h0,          5, 32'h0000_0004, 2};
      tbl[2] = '{1, 0, 1, 32'h0,       32'h0002_2203,  0, 32'h0002_2200, 0};
      tbl[3] = '{2, 1, 0, 32'h0000_0041, 32'h0,        0, 32'h0000_0040, 0};
      tbl[4] = '{3, 1, 1, 32'h0000_0080, 32'h0000_0093, 1, 32'h0000_0090, 0};
      tbl[5] = '{1, 0, 1, 32'h0,       32'hFFFF_FFFC,  0, 32'hFFFF_FFFC, 0};
      tbl[6] = '{3, 0, 0, 32'h0,       32'h0,          1, 32'h0000_0000, 4};

      rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // IDLE ignores redirects
      redirect_valid = 1'b1; redirect_pc = 32'h500;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      chk("idle_redir_pc", pc, 32'h0);
      chk("idle_redir_busy", {31'b0, busy}, 32'd0);

      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      m_pc = 32'h0;
      foreach (tbl[i]) run_entry(tbl[i]);

      // redirect in HOLD with ready high squashes the instruction
      mem_dly = 1;
      wait_valid("squash_pre_valid");
      redirect_valid = 1'b1; redirect_pc = 32'h100; inst_ready = 1'b1;
      @(posedge clk); #1;
      redirect_valid = 1'b0; inst_ready = 1'b0;
      chk("squash_valid", {31'b0, inst_valid}, 32'd0);
      chk("squash_pc", pc, 32'h100);
      m_pc = 32'h100;
      one = '{1, 0, 0, 32'h0, 32'h0, 0, 32'h0000_0100, 2};
      run_entry(one);

      // start while busy acts as a redirect to the boot address
      wait_valid("start_pre_valid");
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_busy_valid", {31'b0, inst_valid}, 32'd0);
      chk("start_busy_pc", pc, 32'h0);
      m_pc = 32'h0;
      one = '{1, 0, 0, 32'h0, 32'h0, 0, 32'h0000_0000, 2};
      run_entry(one);

      // reset mid-request, then the late ack must be ignored
      mem_dly = 3;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("rstmid_req", {31'b0, imem_req}, 32'd0);
      chk("rstmid_busy", {31'b0, busy}, 32'd0);
      chk("rstmid_pc", pc, 32'h0);
      chk("rstmid_inst", inst, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("late_ack_valid", {31'b0, inst_valid}, 32'd0);
         chk("late_ack_busy", {31'b0, busy}, 32'd0);
      end
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      m_pc = 32'h0;
      one = '{1, 0, 0, 32'h0, 32'h0, 0, 32'h0000_0000, 2};
      run_entry(one);

`ifdef FETCH_TIMEOUT_EN
      begin
         int n = 0;
         mem_en = 1'b0;
         while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
         end
         chk("to_cycles", n, 17);
         chk("to_err", {31'b0, fetch_err}, 32'd1);
         chk("to_req", {31'b0, imem_req}, 32'd0);
         chk("to_busy", {31'b0, busy}, 32'd0);
         mem_en = 1'b1;
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         chk("to_err_clr", {31'b0, fetch_err}, 32'd0);
         m_pc = 32'h0;
         one = '{1, 0, 0, 32'h0, 32'h0, 0, 32'h0000_0000, 2};
         run_entry(one);
      end
`endif

      repeat (3) @(posedge clk);
      chk("sb_left", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch engine: the consumer of the program counter.
- Holds the current PC and issues word reads to instruction memory over a req/ack handshake.
- Presents each returned instruction, tagged with its PC, to decode over a valid/ready handshake.
- Supports start-up at a fixed boot address, branch/jump redirect, and decode back-pressure.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset and on start.
- PC_STEP, 4, byte increment added to the PC after each accepted instruction.
- TIMEOUT_CYCLES, 16, ack wait limit; used only when FETCH_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  sync pulse; reload PC=RESET_PC and begin fetching.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  target PC; bits[1:0] are ignored and forced to 0.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  word-aligned read address.
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts the instruction.
- inst  out  32  instruction word.
- inst_pc  out  32  PC of inst.
- pc  out  32  current fetch PC.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, inst=0, inst_pc=0.
  - imem_req=0, inst_valid=0, busy=0, discard flag=0.
  - Reset asserted mid-request drops the request immediately; a late imem_ack after reset is ignored.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - start=1 -> pc=RESET_PC, go to REQ.
  - All other inputs, including redirect, are ignored.
- REQ:
  - imem_req=1, imem_addr=pc; go to WAIT next cycle.
  - imem_req stays high through WAIT until ack.
- WAIT, on imem_ack=1:
  - Discard flag clear: latch inst=imem_rdata and inst_pc=pc; set inst_valid=1; go to HOLD. Latency from request to inst_valid is 2 cycles minimum.
  - Discard flag set: drop the data, clear the flag, go to REQ with the new pc.
- HOLD:
  - inst_valid stays high and inst/inst_pc are stable until inst_ready=1.
  - On acceptance (inst_valid & inst_ready): pc=pc+PC_STEP mod 2^32, wrapping 0xFFFFFFFC -> 0x00000000. Go to REQ the same edge, so back-to-back throughput is 1 instruction per 3 cycles.
- Redirect (redirect_valid=1, any state except IDLE):
  - pc=redirect_pc & ~3. The redirect overrides the +PC_STEP increment in the same cycle.
  - In HOLD: inst_valid drops next edge, even if inst_ready is high the same cycle (instruction squashed); go to REQ.
  - In REQ/WAIT with a request outstanding: set the discard flag; the outstanding request completes normally (never abandoned).
  - Multiple redirects before ack: the last one wins.
- start while not IDLE: treated as a redirect to RESET_PC.
- imem_addr=pc whenever imem_req=1; otherwise holds its last value.
- busy = (state != IDLE).

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - Adds output fetch_err (1 bit, reset 0) and a wait counter (reset 0, cleared on entering WAIT).
  - When the counter reaches TIMEOUT_CYCLES with no ack: fetch_err=1 (sticky until rst_n or start), imem_req=0, go to IDLE.
  - An ack arriving the same cycle the limit is reached wins, and no error is raised.
- Not defined: no fetch_err port, no counter; WAIT waits indefinitely.

Test Plan:
- Reset then start, memory acks 1 cycle after req with 0xAAAA0001 -> imem_addr=0x00000000, inst=0xAAAA0001, inst_pc=0x0, inst_valid 2 cycles after start; pc becomes 0x4 when inst_ready=1.
- Hold inst_ready=0 for 5 cycles -> inst/inst_pc stable and no new imem_req; release ready -> next imem_addr=0x4.
- Redirect to 0x00022203 while in WAIT -> the outstanding ack's data is discarded (inst_valid stays 0), the next request is at 0x00022200, and the instruction delivered carries inst_pc=0x00022200.
- Redirect to 0x100 in HOLD with inst_ready=1 the same cycle -> instruction squashed (not consumed as accepted), pc=0x100, not 0x4.
- Redirect to 0xFFFFFFFC, accept one instruction -> pc wraps to 0x00000000.
- With FETCH_TIMEOUT_EN, no ack for 16 cycles -> fetch_err=1, imem_req=0, busy=0; start clears fetch_err and fetch resumes at RESET_PC.
